cr_huf_comp_sc_long: RTL and testbench

// - Long-symbol counter stage that sits directly upstream of the long-symbol insertion sort.
// - Accumulates per-symbol frequencies of long (length/distance) symbols for one block.
// - At end of block, scans the histogram and hands each non-zero (symbol, count) pair to the sort stage

---
 rtl/cr_huf_comp_sc_long_if.sv | 39 +++
 rtl/cr_huf_comp_sc_long.sv | 180 ++++++++++++++++++
 tb/tb_cr_huf_comp_sc_long.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/cr_huf_comp_sc_long_if.sv
// rtl/cr_huf_comp_sc_long_if.sv - handshake bundle between lz, long-symbol counter and insertion sort
//
// Groups the lz_sc_long_* input beat stream, its ready, and the sc_is_long_*
// output pair stream with its pop strobe.
//   master : upstream/downstream side (drives beats and is_sc_long_rd)
//   slave  : counter stage side (drives rdy and the output pair)
interface cr_huf_comp_sc_long_if #(
    parameter int DAT_WIDTH   = 6,
    parameter int CNT_WIDTH   = 16,
    parameter int SEQID_WIDTH = 8
);
    logic                   lz_sc_long_vld;
    logic [DAT_WIDTH-1:0]   lz_sc_long_sym;
    logic                   lz_sc_long_sym_en;
    logic                   lz_sc_long_eob;
    logic [SEQID_WIDTH-1:0] lz_sc_long_seq_id;
    logic                   sc_lz_long_rdy;

    logic                   sc_is_long_vld;
    logic [DAT_WIDTH-1:0]   sc_is_long_sym;
    logic [CNT_WIDTH-1:0]   sc_is_long_cnt;
    logic [SEQID_WIDTH-1:0] sc_is_long_seq_id;
    logic                   sc_is_long_eob;
    logic                   is_sc_long_rd;

    modport master (
        output lz_sc_long_vld, lz_sc_long_sym, lz_sc_long_sym_en,
               lz_sc_long_eob, lz_sc_long_seq_id, is_sc_long_rd,
        input  sc_lz_long_rdy, sc_is_long_vld, sc_is_long_sym,
               sc_is_long_cnt, sc_is_long_seq_id, sc_is_long_eob
    );

    modport slave (
        input  lz_sc_long_vld, lz_sc_long_sym, lz_sc_long_sym_en,
               lz_sc_long_eob, lz_sc_long_seq_id, is_sc_long_rd,
        output sc_lz_long_rdy, sc_is_long_vld, sc_is_long_sym,
               sc_is_long_cnt, sc_is_long_seq_id, sc_is_long_eob
    );
endinterface

// File: rtl/cr_huf_comp_sc_long.sv
// rtl/cr_huf_comp_sc_long.sv - long-symbol frequency counter feeding the long-symbol insertion sort
//
// Accumulates a saturating histogram of long symbols for one block, then
// walks it and hands every non-zero (symbol, count) pair to the sort stage,
// flagging the last pair of the block with eob.
//
// Ports:
//   clk               clock
//   rst               asynchronous active-high reset
//   bus (slave)       lz_sc_long_* beat stream in, sc_lz_long_rdy out,
//                     sc_is_long_* pair stream out, is_sc_long_rd in
//   sc_long_sym_err   sticky flag: an out-of-range symbol was received
//   sc_long_stall_cnt cycles a pair waited un-popped (saturating), present
//                     only when CR_HUF_COMP_SC_LONG_STALL_CNT_EN is defined
//
// Optional feature macro: CR_HUF_COMP_SC_LONG_STALL_CNT_EN
module cr_huf_comp_sc_long #(
    parameter int DAT_WIDTH   = 6,
    parameter int NUM_SYM     = 30,
    parameter int CNT_WIDTH   = 16,
    parameter int SEQID_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    cr_huf_comp_sc_long_if.slave  bus,
`ifdef CR_HUF_COMP_SC_LONG_STALL_CNT_EN
    output logic [15:0]           sc_long_stall_cnt,
`endif
    output logic                  sc_long_sym_err
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [DAT_WIDTH:0]   NUM_SYM_W = (DAT_WIDTH+1)'(NUM_SYM);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [CNT_WIDTH-1:0]   cnt [NUM_SYM];
    logic [DAT_WIDTH-1:0]   ptr;
    logic [SEQID_WIDTH-1:0] seq_lat;

    logic [DAT_WIDTH-1:0]   out_sym;
    logic [CNT_WIDTH-1:0]   out_cnt;
    logic [SEQID_WIDTH-1:0] out_seq;
    logic                   out_eob;
    logic                   sym_err;

    logic [NUM_SYM-1:0]     nz;
    logic [CNT_WIDTH-1:0]   cur_cnt;
    logic                   cur_nz;
    logic                   any_above;
    logic                   fire;
    logic                   sym_ok;
    logic                   emit_now;
    logic                   pop;

    // Beat acceptance and entry selection at ptr.
    always_comb begin
        fire      = bus.lz_sc_long_vld && (state == ACCUM);
        sym_ok    = {1'b0, bus.lz_sc_long_sym} < NUM_SYM_W;
        pop       = (state == EMIT) && bus.is_sc_long_rd;
        nz        = '0;
        cur_cnt   = '0;
        any_above = 1'b0;
        for (int i = 0; i < NUM_SYM; i++) begin
            nz[i] = (cnt[i] != '0);
            if (ptr == DAT_WIDTH'(i)) begin
                cur_cnt = cnt[i];
            end
            // eob of the pair at ptr: nothing non-zero left above it
            if (nz[i] && ((DAT_WIDTH+1)'(i) > {1'b0, ptr})) begin
                any_above = 1'b1;
            end
        end
        cur_nz   = (cur_cnt != '0);
        // An all-zero histogram in SCAN can only be an empty block; it still
        // produces one (0, 0, eob) pair so the sort stage sees the block end.
        emit_now = (state == SCAN) && (cur_nz || (nz == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: begin
                if (fire && bus.lz_sc_long_eob) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (emit_now) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (bus.is_sc_long_rd) begin
                    state_nxt = out_eob ? ACCUM : SCAN;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                cnt[i] <= '0;
            end
            ptr     <= '0;
            seq_lat <= '0;
            out_sym <= '0;
            out_cnt <= '0;
            out_seq <= '0;
            out_eob <= 1'b0;
            sym_err <= 1'b0;
        end else begin
            if (fire && bus.lz_sc_long_eob) begin
                seq_lat <= bus.lz_sc_long_seq_id;
            end
            if (fire && bus.lz_sc_long_sym_en && !sym_ok) begin
                sym_err <= 1'b1;
            end
            // fire (ACCUM) and pop (EMIT) never coincide, so the increment and
            // the clear below never target cnt in the same cycle.
            for (int i = 0; i < NUM_SYM; i++) begin
                if (fire && bus.lz_sc_long_sym_en && sym_ok &&
                    (bus.lz_sc_long_sym == DAT_WIDTH'(i)) && (cnt[i] != CNT_MAX)) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
                if (pop && (ptr == DAT_WIDTH'(i))) begin
                    cnt[i] <= '0;
                end
            end
            if (state == SCAN) begin
                if (emit_now) begin
                    out_sym <= ptr;
                    out_cnt <= cur_cnt;
                    out_seq <= seq_lat;
                    out_eob <= !any_above;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end
            if (pop) begin
                ptr <= out_eob ? '0 : ptr + 1'b1;
            end
        end
    end

`ifdef CR_HUF_COMP_SC_LONG_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_long_stall_cnt <= '0;
        end else if ((state == EMIT) && !bus.is_sc_long_rd && (sc_long_stall_cnt != 16'hFFFF)) begin
            sc_long_stall_cnt <= sc_long_stall_cnt + 1'b1;
        end
    end
`endif

    // vld is exactly "a pair is being presented", i.e. the EMIT state.
    assign bus.sc_lz_long_rdy    = (state == ACCUM);
    assign bus.sc_is_long_vld    = (state == EMIT);
    assign bus.sc_is_long_sym    = out_sym;
    assign bus.sc_is_long_cnt    = out_cnt;
    assign bus.sc_is_long_seq_id = out_seq;
    assign bus.sc_is_long_eob    = out_eob;
    assign sc_long_sym_err       = sym_err;
endmodule

// File: tb/tb_cr_huf_comp_sc_long.sv
// tb/tb_cr_huf_comp_sc_long.sv - self-checking bench for cr_huf_comp_sc_long
module tb_cr_huf_comp_sc_long;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cr_huf_comp_sc_long_if #(.DAT_WIDTH(6), .CNT_WIDTH(16), .SEQID_WIDTH(8)) bus();
    logic sym_err;
`ifdef CR_HUF_COMP_SC_LONG_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    cr_huf_comp_sc_long #(
        .DAT_WIDTH(6), .NUM_SYM(30), .CNT_WIDTH(16), .SEQID_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
`ifdef CR_HUF_COMP_SC_LONG_STALL_CNT_EN
        .sc_long_stall_cnt(stall_cnt),
`endif
        .sc_long_sym_err(sym_err)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        int               nb;
        logic [3:0][5:0]  syms;
        logic             en_last;
        logic [7:0]       seq;
        int               np;
        logic [3:0][5:0]  psym;
        logic [3:0][15:0] pcnt;
        int               lat;
    } blk_t;

    blk_t blk [5];

    function automatic blk_t mk(int nb, int s0, int s1, int s2, int s3, int en_last, int seq,
                                int np, int p0, int p1, int p2, int p3,
                                int c0, int c1, int c2, int c3, int lat);
        blk_t b;
        b.nb      = nb;
        b.syms[0] = 6'(s0);
        b.syms[1] = 6'(s1);
        b.syms[2] = 6'(s2);
        b.syms[3] = 6'(s3);
        b.en_last = 1'(en_last);
        b.seq     = 8'(seq);
        b.np      = np;
        b.psym[0] = 6'(p0);
        b.psym[1] = 6'(p1);
        b.psym[2] = 6'(p2);
        b.psym[3] = 6'(p3);
        b.pcnt[0] = 16'(c0);
        b.pcnt[1] = 16'(c1);
        b.pcnt[2] = 16'(c2);
        b.pcnt[3] = 16'(c3);
        b.lat     = lat;
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [5:0] s, input logic en, input logic e, input logic [7:0] q);
        @(negedge clk);
        bus.lz_sc_long_vld    = 1'b1;
        bus.lz_sc_long_sym    = s;
        bus.lz_sc_long_sym_en = en;
        bus.lz_sc_long_eob    = e;
        bus.lz_sc_long_seq_id = q;
        @(posedge clk);
        #1;
        bus.lz_sc_long_vld    = 1'b0;
        bus.lz_sc_long_eob    = 1'b0;
    endtask

    // Returns the number of clock edges waited before vld was seen at a negedge.
    task automatic wait_vld(output int n);
        n = 0;
        @(negedge clk);
        while (!bus.sc_is_long_vld && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("vld_seen", 32'(bus.sc_is_long_vld), 32'd1);
    endtask

    // Called at a negedge with vld high: check the pair, pop it, check aftermath.
    task automatic pop_pair(input string tag, input logic [5:0] es, input logic [15:0] ec,
                            input logic ee, input logic [7:0] eq);
        chk({tag, "_sym"}, 32'(bus.sc_is_long_sym), 32'(es));
        chk({tag, "_cnt"}, 32'(bus.sc_is_long_cnt), 32'(ec));
        chk({tag, "_eob"}, 32'(bus.sc_is_long_eob), 32'(ee));
        chk({tag, "_seq"}, 32'(bus.sc_is_long_seq_id), 32'(eq));
        chk({tag, "_rdy_busy"}, 32'(bus.sc_lz_long_rdy), 32'd0);
        bus.is_sc_long_rd = 1'b1;
        @(posedge clk);
        #1;
        bus.is_sc_long_rd = 1'b0;
        @(negedge clk);
        chk({tag, "_vld_drop"}, 32'(bus.sc_is_long_vld), 32'd0);
        if (ee) begin
            chk({tag, "_rdy_back"}, 32'(bus.sc_lz_long_rdy), 32'd1);
        end
    endtask

    initial begin
        int n;
        logic [5:0]  h_sym;
        logic [15:0] h_cnt;
        logic [7:0]  h_seq;
        logic        h_eob;
        logic        stable;

        blk[0] = mk(4,  3,  3,  7,  3, 1, 'h11, 2,  3,  7,  0, 0, 3, 1, 0, 0, 5);
        blk[1] = mk(4, 29,  0,  1, 29, 1, 'hA5, 3,  0,  1, 29, 0, 1, 1, 2, 0, 2);
        blk[2] = mk(1,  5,  0,  0,  0, 0, 'h2A, 1,  0,  0,  0, 0, 0, 0, 0, 0, 2);
        blk[3] = mk(3, 30, 31,  0,  0, 1, 'h5C, 1,  0,  0,  0, 0, 1, 0, 0, 0, 2);
        blk[4] = mk(3, 12, 12, 12,  0, 0, 'h77, 1, 12,  0,  0, 0, 2, 0, 0, 0, 14);

        bus.lz_sc_long_vld    = 1'b0;
        bus.lz_sc_long_sym    = '0;
        bus.lz_sc_long_sym_en = 1'b0;
        bus.lz_sc_long_eob    = 1'b0;
        bus.lz_sc_long_seq_id = '0;
        bus.is_sc_long_rd     = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 32'(bus.sc_lz_long_rdy), 32'd1);
        chk("rst_vld", 32'(bus.sc_is_long_vld), 32'd0);
        chk("rst_sym", 32'(bus.sc_is_long_sym), 32'd0);
        chk("rst_cnt", 32'(bus.sc_is_long_cnt), 32'd0);
        chk("rst_seq", 32'(bus.sc_is_long_seq_id), 32'd0);
        chk("rst_eob", 32'(bus.sc_is_long_eob), 32'd0);
        chk("rst_err", 32'(sym_err), 32'd0);
`ifdef CR_HUF_COMP_SC_LONG_STALL_CNT_EN
        chk("rst_stall", 32'(stall_cnt), 32'd0);
`endif
        rst = 1'b0;

        for (int b = 0; b < 5; b++) begin
            for (int j = 0; j < blk[b].nb; j++) begin
                send_beat(blk[b].syms[j], (j == blk[b].nb - 1) ? blk[b].en_last : 1'b1,
                          j == blk[b].nb - 1, blk[b].seq);
            end
            wait_vld(n);
            chk($sformatf("blk%0d_latency", b), 32'(n), 32'(blk[b].lat - 1));
            for (int p = 0; p < blk[b].np; p++) begin
                if (p > 0) begin
                    wait_vld(n);
                end
                pop_pair($sformatf("blk%0d_p%0d", b, p), blk[b].psym[p], blk[b].pcnt[p],
                         p == blk[b].np - 1, blk[b].seq);
            end
            chk($sformatf("blk%0d_sym_err", b), 32'(sym_err), (b >= 3) ? 32'd1 : 32'd0);
        end

        // Saturation: 70000 beats of symbol 5, eob on the last.
        for (int i = 0; i < 70000; i++) begin
            send_beat(6'd5, 1'b1, i == 69999, 8'h3C);
        end
        wait_vld(n);
        chk("sat_latency", 32'(n), 32'd6);
        pop_pair("sat", 6'd5, 16'hFFFF, 1'b1, 8'h3C);

        // Hold the first pair for 10 cycles.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_err", 32'(sym_err), 32'd0);
        send_beat(6'd2, 1'b1, 1'b0, 8'h91);
        send_beat(6'd2, 1'b1, 1'b0, 8'h91);
        send_beat(6'd4, 1'b1, 1'b1, 8'h91);
        wait_vld(n);
        h_sym  = bus.sc_is_long_sym;
        h_cnt  = bus.sc_is_long_cnt;
        h_seq  = bus.sc_is_long_seq_id;
        h_eob  = bus.sc_is_long_eob;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.sc_is_long_sym != h_sym || bus.sc_is_long_cnt != h_cnt ||
                bus.sc_is_long_seq_id != h_seq || bus.sc_is_long_eob != h_eob ||
                !bus.sc_is_long_vld || bus.sc_lz_long_rdy) begin
                stable = 1'b0;
            end
        end
        chk("hold_stable", 32'(stable), 32'd1);
`ifdef CR_HUF_COMP_SC_LONG_STALL_CNT_EN
        chk("hold_stall_cnt", 32'(stall_cnt), 32'd10);
`endif
        pop_pair("hold_p0", 6'd2, 16'd2, 1'b0, 8'h91);
        wait_vld(n);
        pop_pair("hold_p1", 6'd4, 16'd1, 1'b1, 8'h91);

        // Asynchronous reset while a pair is presented.
        send_beat(6'd9, 1'b1, 1'b0, 8'hE0);
        send_beat(6'd9, 1'b1, 1'b1, 8'hE0);
        wait_vld(n);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vld", 32'(bus.sc_is_long_vld), 32'd0);
        chk("arst_rdy", 32'(bus.sc_lz_long_rdy), 32'd1);
        chk("arst_cnt", 32'(bus.sc_is_long_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_beat(6'd1, 1'b1, 1'b1, 8'h42);
        wait_vld(n);
        chk("post_rst_latency", 32'(n), 32'd2);
        pop_pair("post_rst", 6'd1, 16'd1, 1'b1, 8'h42);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
